exc_ctrl: RTL

Exception/interrupt sequencer for the multicycle CPU. It samples device interrupt lines and presents them to the CP0 block as HWInt[7:2]. At instruction boundaries it acts on CP0's IntReq or on a completed ERET, and sequences the EPC save, EXL set/clear and PC redirect while holding the main control FSM. It sits between the main controller, the PC register and CP0.

---
 rtl/exc_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: samples device IRQs for CP0 and drives EPC save, EXL strobes and
// PC redirect at instruction boundaries. Define EXC_CTRL_SYNC_EN for a two-flop irq synchronizer.
module exc_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  irq_i,
    output logic [5:0]  hw_int_o,
    input  logic        int_req_i,
    input  logic        instr_done_i,
    input  logic        eret_i,
    input  logic [29:0] next_pc_i,
    input  logic [29:0] epc_i,
    output logic        exl_set_o,
    output logic        exl_clr_o,
    output logic [31:0] cp0_din_o,
    output logic        pc_we_o,
    output logic [29:0] pc_out_o,
    output logic        hold_o,
    output logic [2:0]  irq_id_o,
    output logic [15:0] int_cnt_o
);

    typedef enum logic [1:0] {
        StIdle,
        StSave,
        StVector,
        StRet
    } state_e;

    state_e      state_q, state_d;
    logic [29:0] saved_pc_q, saved_pc_d;
    logic [15:0] int_cnt_q, int_cnt_d;
    logic [5:0]  hw_int_q;

`ifdef EXC_CTRL_SYNC_EN
    logic [5:0] irq_meta_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_meta_q <= '0;
            hw_int_q   <= '0;
        end else begin
            irq_meta_q <= irq_i;
            hw_int_q   <= irq_meta_q;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            hw_int_q <= '0;
        end else begin
            hw_int_q <= irq_i;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            saved_pc_q <= '0;
            int_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            saved_pc_q <= saved_pc_d;
            int_cnt_q  <= int_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        saved_pc_d = saved_pc_q;
        int_cnt_d  = int_cnt_q;
        exl_set_o  = 1'b0;
        exl_clr_o  = 1'b0;
        cp0_din_o  = '0;
        pc_we_o    = 1'b0;
        pc_out_o   = '0;
        hold_o     = 1'b0;
        unique case (state_q)
            StIdle: begin
                // ERET beats a simultaneous IntReq; CP0 re-raises it once EXL clears.
                if (instr_done_i && eret_i) begin
                    state_d = StRet;
                end else if (instr_done_i && int_req_i) begin
                    state_d    = StSave;
                    saved_pc_d = next_pc_i;
                end
            end
            StSave: begin
                exl_set_o = 1'b1;
                cp0_din_o = {saved_pc_q, 2'b00};
                hold_o    = 1'b1;
                state_d   = StVector;
            end
            StVector: begin
                pc_we_o  = 1'b1;
                pc_out_o = HANDLER_ADDR[31:2];
                hold_o   = 1'b1;
                state_d  = StIdle;
                if (int_cnt_q != 16'hFFFF) begin
                    int_cnt_d = int_cnt_q + 16'd1;
                end
            end
            StRet: begin
                exl_clr_o = 1'b1;
                pc_we_o   = 1'b1;
                pc_out_o  = epc_i;
                hold_o    = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Ascending scan so the highest set bit wins.
    always_comb begin
        irq_id_o = 3'd7;
        for (int i = 0; i < 6; i++) begin
            if (hw_int_q[i]) begin
                irq_id_o = 3'(i);
            end
        end
    end

    assign hw_int_o  = hw_int_q;
    assign int_cnt_o = int_cnt_q;

endmodule
